// File: rtl/nios_core_cpu_debug_pkg.sv
// Shared definitions for the debug-slave command synchroniser: FSM states and
// the bit positions inside the sticky status vector.
package nios_core_cpu_debug_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CAPTURE   = 2'd1,
    ST_ISSUE     = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  localparam int unsigned STAT_W           = 3;
  localparam int unsigned STAT_OVERFLOW    = 0;
  localparam int unsigned STAT_TIMEOUT     = 1;
  localparam int unsigned STAT_ERR_UNKNOWN = 2;

endpackage

// File: rtl/nios_core_cpu_debug_slave_cmd_sync_if.sv
// Bundle of the tck-domain command inputs and the clk-domain command outputs
// of the debug-slave command synchroniser.
interface nios_core_cpu_debug_slave_cmd_sync_if #(
  parameter int unsigned SR_W = 38,
  parameter int unsigned IR_W = 2,
  parameter int unsigned N_CH = 4
) ();

  logic [SR_W-1:0] sr;
  logic [IR_W-1:0] ir_in;
  logic            udr_toggle;
  logic            uir_toggle;
  logic [N_CH-1:0] ch_done;
  logic            clr_status;

  logic [SR_W-1:0] jdo;
  logic [N_CH-1:0] take_action;
  logic [N_CH-1:0] take_no_action;
  logic            ir_update;
  logic [IR_W-1:0] ir_q;
  logic            ack_toggle;
  logic            busy;
  logic [nios_core_cpu_debug_pkg::STAT_W-1:0] status;

  modport master (
    output sr, ir_in, udr_toggle, uir_toggle, ch_done, clr_status,
    input  jdo, take_action, take_no_action, ir_update, ir_q, ack_toggle, busy, status
  );

  modport slave (
    input  sr, ir_in, udr_toggle, uir_toggle, ch_done, clr_status,
    output jdo, take_action, take_no_action, ir_update, ir_q, ack_toggle, busy, status
  );

endinterface

// File: rtl/nios_core_cpu_debug_toggle_sync.sv
// Multi-flop synchroniser for a level-toggle signal, producing a one-cycle
// event pulse whenever the synchronised level changes.
module nios_core_cpu_debug_toggle_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tog_i,
  output logic event_o
);

  localparam int unsigned ARM_CNT = SYNC_STAGES + 1;
  localparam int unsigned CNT_W   = $clog2(ARM_CNT + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [CNT_W-1:0]       arm_q;
  logic                   armed;

  // A toggle already high at reset release needs SYNC_STAGES+1 edges to reach
  // prev_q; events stay masked until then so it is absorbed as the baseline.
  assign armed = (arm_q == CNT_W'(ARM_CNT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      arm_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tog_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      if (!armed) arm_q <= arm_q + CNT_W'(1);
    end
  end

  assign event_o = armed & (sync_q[SYNC_STAGES-1] ^ prev_q);

endmodule

// File: rtl/nios_core_cpu_debug_slave_cmd_sync.sv
// Brings JTAG update-DR/update-IR events into the system clock domain, issues
// one-hot command pulses and returns a completion toggle to the tck side.
module nios_core_cpu_debug_slave_cmd_sync
  import nios_core_cpu_debug_pkg::*;
#(
  parameter int unsigned     SR_W        = 38,
  parameter int unsigned     IR_W        = 2,
  parameter int unsigned     N_CH        = 4,
  parameter int unsigned     ACT_BIT     = 37,
  parameter int unsigned     SYNC_STAGES = 2,
  parameter logic [N_CH-1:0] WAIT_MASK   = 4'b0010,
  parameter int unsigned     TIMEOUT     = 255
) (
  input logic clk,
  input logic reset_n,
  nios_core_cpu_debug_slave_cmd_sync_if.slave bus
);

  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic udr_ev;
  logic uir_ev;

  nios_core_cpu_debug_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk    (clk),
    .rst_n  (reset_n),
    .tog_i  (bus.udr_toggle),
    .event_o(udr_ev)
  );

  nios_core_cpu_debug_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk    (clk),
    .rst_n  (reset_n),
    .tog_i  (bus.uir_toggle),
    .event_o(uir_ev)
  );

  state_e            state_q;
  logic [SR_W-1:0]   jdo_q;
  logic [IR_W-1:0]   ir_lat_q;
  logic [N_CH-1:0]   take_act_q;
  logic [N_CH-1:0]   take_noact_q;
  logic              ir_update_q;
  logic              ack_q;
  logic [STAT_W-1:0] status_q;
  logic [TMR_W-1:0]  tmr_q;

  logic [N_CH-1:0]   ch_sel;
  logic              ch_valid;
  logic              ch_waits;
  logic              ch_done_hit;

  // ch_sel is empty for an instruction beyond the decoded channels.
  always_comb begin
    ch_sel = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      ch_sel[i] = (32'(ir_lat_q) == i);
    end
    ch_valid    = |ch_sel;
    ch_waits    = |(ch_sel & WAIT_MASK);
    ch_done_hit = |(ch_sel & bus.ch_done);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      jdo_q        <= '0;
      ir_lat_q     <= '0;
      take_act_q   <= '0;
      take_noact_q <= '0;
      ir_update_q  <= 1'b0;
      ack_q        <= 1'b0;
      status_q     <= '0;
      tmr_q        <= '0;
    end else begin
      take_act_q   <= '0;
      take_noact_q <= '0;
      ir_update_q  <= uir_ev;

      // Flag sets below are later assignments, so they override the clear.
      if (bus.clr_status) status_q <= '0;
      if (uir_ev && (state_q == ST_IDLE)) ir_lat_q <= bus.ir_in;
      if (udr_ev && (state_q != ST_IDLE)) status_q[STAT_OVERFLOW] <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (udr_ev) begin
            jdo_q    <= bus.sr;
            ir_lat_q <= bus.ir_in;
            state_q  <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (ch_valid) begin
            if (jdo_q[ACT_BIT]) take_act_q   <= ch_sel;
            else                take_noact_q <= ch_sel;
          end
          state_q <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (!ch_valid) begin
            status_q[STAT_ERR_UNKNOWN] <= 1'b1;
            ack_q   <= ~ack_q;
            state_q <= ST_IDLE;
          end else if (ch_waits) begin
            tmr_q   <= '0;
            state_q <= ST_WAIT_DONE;
          end else begin
            ack_q   <= ~ack_q;
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT_DONE: begin
          if (ch_done_hit) begin
            ack_q   <= ~ack_q;
            state_q <= ST_IDLE;
          end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
            status_q[STAT_TIMEOUT] <= 1'b1;
            ack_q   <= ~ack_q;
            state_q <= ST_IDLE;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.jdo            = jdo_q;
  assign bus.take_action    = take_act_q;
  assign bus.take_no_action = take_noact_q;
  assign bus.ir_update      = ir_update_q;
  assign bus.ir_q           = ir_lat_q;
  assign bus.ack_toggle     = ack_q;
  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.status         = status_q;

endmodule

// File: tb/tb_nios_core_cpu_debug_slave_cmd_sync.sv
// Randomised scoreboard bench for the debug-slave command synchroniser.
module tb_nios_core_cpu_debug_slave_cmd_sync;

  localparam int unsigned SR_W    = 38;
  localparam int unsigned IR_W    = 2;
  localparam int unsigned N_CH    = 4;
  localparam int unsigned ACT_BIT = 37;
  localparam int          TIMEOUT = 255;
  localparam logic [N_CH-1:0] WMASK = 4'b0010;

  typedef struct {
    int              due;
    logic [SR_W-1:0] jdo;
    logic [N_CH-1:0] ta;
    logic [N_CH-1:0] tna;
  } take_t;

  typedef struct {
    int              due;
    logic [IR_W-1:0] ir;
  } iru_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic prev_ack = 1'b0;
  logic [SR_W-1:0] last_sr = '0;

  take_t takeq[$];
  iru_t  iruq[$];
  int    ackq[$];

  nios_core_cpu_debug_slave_cmd_sync_if #(.SR_W(SR_W), .IR_W(IR_W), .N_CH(N_CH)) bus ();

  nios_core_cpu_debug_slave_cmd_sync #(
    .SR_W       (SR_W),
    .IR_W       (IR_W),
    .N_CH       (N_CH),
    .ACT_BIT    (ACT_BIT),
    .SYNC_STAGES(2),
    .WAIT_MASK  (WMASK),
    .TIMEOUT    (TIMEOUT)
  ) u_dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [63:0] out_vec();
    return 64'({bus.jdo, bus.take_action, bus.take_no_action, bus.ir_update,
                bus.ir_q, bus.ack_toggle, bus.busy, bus.status});
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a pulse or flips ack.
  always @(negedge clk) begin : monitor
    take_t t;
    iru_t  u;
    int    a;
    if (!reset_n) begin
      prev_ack = 1'b0;
    end else begin
      if ((bus.take_action | bus.take_no_action) != '0) begin
        chk("take_expected", 64'(takeq.size() != 0), 64'(1));
        if (takeq.size() != 0) begin
          t = takeq.pop_front();
          chk("take_cycle", 64'(cyc), 64'(t.due));
          chk("take_jdo", 64'(bus.jdo), 64'(t.jdo));
          chk("take_action", 64'(bus.take_action), 64'(t.ta));
          chk("take_no_action", 64'(bus.take_no_action), 64'(t.tna));
        end
      end
      if (bus.ack_toggle !== prev_ack) begin
        prev_ack = bus.ack_toggle;
        chk("ack_expected", 64'(ackq.size() != 0), 64'(1));
        if (ackq.size() != 0) begin
          a = ackq.pop_front();
          chk("ack_cycle", 64'(cyc), 64'(a));
        end
      end
      if (bus.ir_update) begin
        chk("ir_update_expected", 64'(iruq.size() != 0), 64'(1));
        if (iruq.size() != 0) begin
          u = iruq.pop_front();
          chk("ir_update_cycle", 64'(cyc), 64'(u.due));
          chk("ir_q", 64'(bus.ir_q), 64'(u.ir));
        end
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain();
    int g;
    g = 0;
    #1;
    while ((ackq.size() + takeq.size() + iruq.size()) != 0 && g < 300) begin
      @(negedge clk);
      #1;
      g++;
    end
    chk("queues_drained", 64'(ackq.size() + takeq.size() + iruq.size()), 64'(0));
  endtask

  task automatic idle_uir(input logic [IR_W-1:0] v);
    iru_t u;
    @(negedge clk);
    bus.ir_in = v;
    bus.uir_toggle = ~bus.uir_toggle;
    u.due = cyc + 3;
    u.ir  = v;
    iruq.push_back(u);
    wait_cyc(cyc + 4);
  endtask

  // mode: 0 ch_done after random delay, 1 timeout, 2 overflow + same-edge clear,
  // 3 update-IR while waiting. Modes only differ for waiting channels.
  task automatic send_cmd(input logic [SR_W-1:0] s, input logic [IR_W-1:0] ir,
                          input int mode, input bit with_uir);
    int k, c, d;
    logic [N_CH-1:0] oh;
    logic [2:0] exp_st;
    take_t t;
    iru_t u;
    @(negedge clk);
    bus.sr = s;
    bus.ir_in = ir;
    bus.udr_toggle = ~bus.udr_toggle;
    if (with_uir) bus.uir_toggle = ~bus.uir_toggle;
    k = cyc + 1;
    oh = N_CH'(1) << ir;
    exp_st = '0;
    t.due = k + 3;
    t.jdo = s;
    t.ta  = s[ACT_BIT] ? oh : '0;
    t.tna = s[ACT_BIT] ? '0 : oh;
    takeq.push_back(t);
    if (with_uir) begin
      u.due = k + 2;
      u.ir  = ir;
      iruq.push_back(u);
    end
    wait_cyc(k + 1);
    chk("jdo_before_latency", 64'(bus.jdo), 64'(last_sr));
    chk("busy_before", 64'(bus.busy), 64'(0));
    wait_cyc(k + 2);
    chk("jdo_latency", 64'(bus.jdo), 64'(s));
    chk("busy_capture", 64'(bus.busy), 64'(1));
    last_sr = s;
    if (!WMASK[ir]) begin
      ackq.push_back(k + 4);
      wait_cyc(k + 4);
      chk("busy_after_issue", 64'(bus.busy), 64'(0));
    end else begin
      wait_cyc(k + 4);
      case (mode)
        1: begin
          ackq.push_back(k + 4 + TIMEOUT);
          exp_st = 3'b010;
          for (int i = 0; i < TIMEOUT; i++) begin
            if (i == TIMEOUT - 1) chk("busy_wait_last", 64'(bus.busy), 64'(1));
            bus.ch_done = N_CH'($urandom) & ~oh;
            @(negedge clk);
          end
          bus.ch_done = '0;
          chk("busy_after_timeout", 64'(bus.busy), 64'(0));
        end
        2: begin
          wait_cyc(k + 8);
          c = cyc;
          bus.sr = ~s;
          bus.udr_toggle = ~bus.udr_toggle;
          wait_cyc(c + 2);
          bus.clr_status = 1'b1;
          @(negedge clk);
          bus.clr_status = 1'b0;
          chk("jdo_hold_overflow", 64'(bus.jdo), 64'(s));
          chk("overflow_beats_clear", 64'(bus.status), 64'(3'b001));
          exp_st = 3'b001;
          bus.ch_done = oh;
          ackq.push_back(cyc + 1);
          @(negedge clk);
          bus.ch_done = '0;
        end
        3: begin
          wait_cyc(k + 8);
          c = cyc;
          bus.ir_in = ~ir;
          bus.uir_toggle = ~bus.uir_toggle;
          u.due = c + 3;
          u.ir  = ir;
          iruq.push_back(u);
          wait_cyc(c + 4);
          bus.ch_done = oh;
          ackq.push_back(cyc + 1);
          @(negedge clk);
          bus.ch_done = '0;
        end
        default: begin
          d = $urandom_range(0, 20);
          for (int i = 0; i < d; i++) begin
            bus.ch_done = N_CH'($urandom) & ~oh;
            @(negedge clk);
          end
          chk("busy_in_wait", 64'(bus.busy), 64'(1));
          bus.ch_done = N_CH'($urandom) | oh;
          ackq.push_back(cyc + 1);
          @(negedge clk);
          bus.ch_done = '0;
          chk("busy_after_done", 64'(bus.busy), 64'(0));
        end
      endcase
    end
    drain();
    chk("status_after_cmd", 64'(bus.status), 64'(exp_st));
    if (exp_st != '0) begin
      @(negedge clk);
      bus.clr_status = 1'b1;
      @(negedge clk);
      bus.clr_status = 1'b0;
      chk("status_cleared", 64'(bus.status), 64'(0));
    end
  endtask

  task automatic reset_mid_wait();
    int k;
    take_t t;
    @(negedge clk);
    bus.sr = 38'h20_DEAD_BEEF;
    bus.ir_in = 2'd1;
    bus.udr_toggle = ~bus.udr_toggle;
    k = cyc + 1;
    t.due = k + 3;
    t.jdo = 38'h20_DEAD_BEEF;
    t.ta  = 4'b0010;
    t.tna = '0;
    takeq.push_back(t);
    wait_cyc(k + 20);
    chk("busy_before_reset", 64'(bus.busy), 64'(1));
    #2 reset_n = 1'b0;
    #1 chk("outputs_in_reset", out_vec(), 64'(0));
    ackq.delete();
    takeq.delete();
    iruq.delete();
    bus.udr_toggle = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    last_sr = '0;
    repeat (8) @(negedge clk);
    #1 chk("idle_after_reset", out_vec(), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SR_W-1:0] s;
    logic [IR_W-1:0] ir;
    int mode;
    bus.sr = '0;
    bus.ir_in = '0;
    bus.udr_toggle = 1'b1;
    bus.uir_toggle = 1'b0;
    bus.ch_done = '0;
    bus.clr_status = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("reset_state", out_vec(), 64'(0));
    @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (8) @(negedge clk);
    #1 chk("no_event_from_high_toggle", out_vec(), 64'(0));

    send_cmd(38'h20_0000_0001, 2'd1, 0, 1'b0);
    send_cmd(38'h0F_1234_5678, 2'd2, 0, 1'b0);
    send_cmd(38'h21_5555_AAAA, 2'd1, 1, 1'b0);
    send_cmd(38'h20_1111_2222, 2'd1, 2, 1'b0);
    send_cmd(38'h00_CAFE_F00D, 2'd1, 3, 1'b0);
    send_cmd(38'h3A_0BAD_F00D, 2'd3, 0, 1'b1);
    reset_mid_wait();
    send_cmd(38'h3F_FFFF_FFFF, 2'd0, 0, 1'b0);

    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(0, 1) == 1) idle_uir(IR_W'($urandom));
      s  = SR_W'({$urandom, $urandom});
      ir = IR_W'($urandom);
      mode = (ir == 2'd1) ? int'($urandom_range(0, 3)) : 0;
      send_cmd(s, ir, mode, $urandom_range(0, 3) == 0);
    end

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nios_core_cpu_debug_slave_cmd_sync.md
NIOS_CORE_CPU_DEBUG_SLAVE_CMD_SYNC -- requirements
Module: nios_core_cpu_debug_slave_cmd_sync

Interface
REQ-001 SHALL have parameter SR_W, default 38, JTAG data-register width.
REQ-002 SHALL have parameter IR_W, default 2, JTAG instruction width.
REQ-003 SHALL have parameter N_CH, default 4, decoded command channels (N_CH <= 2**IR_W).
REQ-004 SHALL have parameter ACT_BIT, default 37, sr bit selecting action vs no-action.
REQ-005 SHALL have parameter SYNC_STAGES, default 2 (minimum 2), synchroniser depth.
REQ-006 SHALL have parameter WAIT_MASK, default 4'b0010 (N_CH bits), channels that wait for ch_done.
REQ-007 SHALL have parameter TIMEOUT, default 255, cycles allowed in WAIT_DONE.
REQ-008 SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
REQ-009 SHALL have port clk, input, 1, system clock.
REQ-010 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-011 SHALL have port sr, input, SR_W, data register from the tck domain, stable while a toggle is in flight.
REQ-012 SHALL have port ir_in, input, IR_W, instruction from the tck domain, stable like sr.
REQ-013 SHALL have ports udr_toggle and uir_toggle, input, 1 each; each toggles once per update-DR or update-IR event.
REQ-014 SHALL have port ch_done, input, N_CH, completion pulse per channel.
REQ-015 SHALL have port clr_status, input, 1, clears the sticky status flags.
REQ-016 SHALL have port jdo, output, SR_W, captured data register.
REQ-017 SHALL have ports take_action and take_no_action, output, N_CH each, one-cycle command pulses.
REQ-018 SHALL have ports ir_update (output, 1, one-cycle pulse) and ir_q (output, IR_W, latched instruction).
REQ-019 SHALL have port ack_toggle, output, 1, toggles once per completed command (returned to the tck domain).
REQ-020 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.
REQ-021 SHALL have port status, output, 3, sticky flags {err_unknown, timeout, overflow}.

Function
REQ-022 SHALL pass each toggle through SYNC_STAGES flops; an event is a mismatch between the last stage and a held previous value.
REQ-023 SHALL load the previous-value registers from the synchronised value in the first cycle after reset; a toggle that is already high at reset release SHALL NOT produce an event.
REQ-024 SHALL implement FSM states IDLE, CAPTURE, ISSUE and WAIT_DONE.
REQ-025 IDLE: on a udr event, SHALL latch jdo<=sr and ir_q<=ir_in at that edge and go to CAPTURE.
REQ-026 Latency: with a toggle sampled at edge k, jdo SHALL update at edge k+SYNC_STAGES and the take pulse SHALL be registered at edge k+SYNC_STAGES+1.
REQ-027 CAPTURE SHALL always go to ISSUE on the next edge.
REQ-028 ISSUE SHALL pulse exactly one bit, index ir_q, for one cycle: take_action if jdo[ACT_BIT]=1, otherwise take_no_action.
REQ-029 ISSUE with ir_q >= N_CH SHALL pulse nothing, set err_unknown, toggle ack_toggle, and go to IDLE.
REQ-030 ISSUE SHALL go to WAIT_DONE if WAIT_MASK[ir_q]=1; otherwise it SHALL toggle ack_toggle and go to IDLE.
REQ-031 WAIT_DONE: when ch_done[ir_q]=1, SHALL toggle ack_toggle and go to IDLE; ch_done bits of other channels SHALL be ignored.
REQ-032 WAIT_DONE: after TIMEOUT cycles without ch_done[ir_q], SHALL set timeout, toggle ack_toggle, and go to IDLE.
REQ-033 A udr event outside IDLE SHALL be dropped and SHALL set overflow; jdo SHALL be unchanged.
REQ-034 A uir event in any state SHALL latch ir_q (IDLE only) and pulse ir_update one cycle after detection.
REQ-035 Simultaneous udr and uir events in IDLE SHALL be both honoured: ir_update pulses and the FSM enters CAPTURE.
REQ-036 clr_status SHALL clear all three flags; a flag set in the same cycle as clr_status SHALL win.

Reset
REQ-037 Reset SHALL set: state=IDLE; jdo=0; ir_q=0; all pulses=0; ack_toggle=0; busy=0; status=0; synchroniser stages and timeout counter=0.
REQ-038 Reset asserted mid-command SHALL abandon the command with no pulse and no ack_toggle toggle.

Structure
REQ-039 The FSM state encoding and status bit indices SHALL live in a shared package, nios_core_cpu_debug_pkg.
REQ-040 Sub-module nios_core_cpu_debug_toggle_sync (synchroniser plus event detect, parameter SYNC_STAGES) SHALL be instantiated once per toggle input.

Verification
REQ-041 Scenario: sr=38'h20_0000_0001, ir_in=1, toggle udr -> jdo updates at edge k+2; take_action=4'b0010 at edge k+3; busy stays high until ch_done[1], then ack_toggle flips.
REQ-042 Scenario: sr bit37=0, ir_in=2, toggle udr -> take_no_action=4'b0100 for one cycle; ack_toggle flips one edge later; no wait.
REQ-043 Scenario: ir_in=1, ch_done is never asserted -> after 255 cycles in WAIT_DONE, status=3'b010, FSM returns to IDLE, ack_toggle flips.
REQ-044 Scenario: second udr toggle while in WAIT_DONE -> status=3'b001, jdo unchanged, exactly one take pulse in total.
REQ-045 Scenario: udr_toggle=1 held through reset release -> no event; subsequent toggle to 0 -> exactly one event.
REQ-046 Scenario: reset_n low during WAIT_DONE -> all outputs 0 immediately; after release, the FSM is in IDLE with no ack_toggle flip.
